// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_ctrl
// Brief   : Serialises instruction fetches and load/stores onto a byte RAM bus.
// Rev     : 1.0
// ============================================================================
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_enable,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              ls_enable,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;
    logic [31:0]         if_data_q, if_data_d;
    logic [31:0]         ls_rdata_q, ls_rdata_d;
    logic                if_done_q, if_done_d;
    logic                ls_done_q, ls_done_d;
    logic [31:0]         buf_q, buf_d;

    logic [3:0]          w_n;
    logic [1:0]          w_last;
    logic [1:0]          w_idx;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_result;
    logic                w_ls_go;
    logic                w_if_go;

    always_comb begin
        w_n = 4'd4;
        if (state_q != IFETCH) begin
            case (ls_size)
                2'd0:    w_n = 4'd1;
                2'd1:    w_n = 4'd2;
                default: w_n = 4'd4;
            endcase
        end
    end

    assign w_last  = w_n[1:0] - 2'd1;
    assign w_idx   = cnt_q[1:0] - 2'd2;
    assign w_addr  = (state_q == IFETCH) ? if_addr : ls_addr;
    // IO stores are held off while the IO buffer is full; the fetch port may go instead.
    assign w_ls_go = ls_enable && !ls_done_q &&
                     !(ls_wr && (ls_addr[17:16] == IO_HI) && io_buffer_full);
    assign w_if_go = if_enable && !if_done_q && !clear;

    // Final read byte comes straight from the bus; unread upper bytes stay zero.
    always_comb begin
        w_result = buf_q;
        w_result[{w_last, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        buf_d      = buf_q;
        if (rdy) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    mem_wr_d = 1'b0;
                    if (w_ls_go) begin
                        mem_a_d = ls_addr;
                        cnt_d   = 4'd1;
                        buf_d   = '0;
                        if (ls_wr) begin
                            state_d    = STORE;
                            mem_dout_d = ls_wdata[7:0];
                            mem_wr_d   = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end else if (w_if_go) begin
                        mem_a_d = if_addr;
                        cnt_d   = 4'd1;
                        buf_d   = '0;
                        state_d = IFETCH;
                    end
                end
                IFETCH, LOAD: begin
                    if ((state_q == IFETCH) && clear) begin
                        state_d  = IDLE;
                        cnt_d    = 4'd0;
                        mem_wr_d = 1'b0;
                    end else if (cnt_q == w_n + 4'd1) begin
                        if (state_q == IFETCH) begin
                            if_data_d = w_result;
                            if_done_d = 1'b1;
                        end else begin
                            ls_rdata_d = w_result;
                            ls_done_d  = 1'b1;
                        end
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        if (cnt_q >= 4'd2) begin
                            buf_d[{w_idx, 3'b000} +: 8] = mem_din;
                        end
                        if (cnt_q < w_n) begin
                            mem_a_d = w_addr + ADDR_W'(cnt_q);
                        end
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                STORE: begin
                    if (cnt_q == w_n) begin
                        mem_wr_d  = 1'b0;
                        ls_done_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = 4'd0;
                    end else begin
                        mem_a_d    = ls_addr + ADDR_W'(cnt_q);
                        mem_dout_d = ls_wdata[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_d      = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            buf_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            buf_q      <= buf_d;
        end
    end

    assign if_data  = if_data_q;
    assign if_done  = if_done_q;
    assign ls_rdata = ls_rdata_q;
    assign ls_done  = ls_done_q;
    assign mem_dout = mem_dout_q;
    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_ctrl
// Brief   : Directed scoreboard bench for mem_ctrl with a byte RAM model.
// Rev     : 1.0
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_enable;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        ls_enable, ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        ls_done;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:65535];
    logic [31:0] if_q[$];
    logic [31:0] ls_q[$];
    logic [39:0] wexp[$];
    logic [39:0] wlog[$];

    int total = 0;
    int bad   = 0;
    int n;

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_enable(if_enable), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .ls_enable(ls_enable), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM answers one cycle after the address; it stalls with the rest of the system.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[15:0]];
        if (mem_wr && rdy && !rst) wlog.push_back({mem_a, mem_dout});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit want_if, input int max, output int cnt);
        cnt = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((want_if ? if_done : ls_done) === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(wlog.size()), 64'(wexp.size()));
        while (wexp.size() > 0 && wlog.size() > 0)
            check(tag, 64'(wlog.pop_front()), 64'(wexp.pop_front()));
        wexp.delete();
        wlog.delete();
    endtask

    task automatic push_word_writes(input logic [31:0] a, input logic [31:0] d, input int nb);
        for (int i = 0; i < nb; i++) wexp.push_back({a + 32'(i), d[8*i +: 8]});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h100] = 8'h13; ram[16'h101] = 8'h05; ram[16'h102] = 8'h00; ram[16'h103] = 8'h00;
        ram[16'h104] = 8'h93; ram[16'h105] = 8'h00; ram[16'h106] = 8'h10; ram[16'h107] = 8'h00;
        ram[16'h200] = 8'hF0;

        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_enable = 1'b0; if_addr = '0;
        ls_enable = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
        tick(); tick();
        check("reset_ctl", {mem_a, mem_dout, mem_wr, if_done, ls_done}, 64'd0);
        check("reset_data", {if_data, ls_rdata}, 64'd0);

        // Word fetch with an explicit bus address trace
        rst = 1'b0;
        if_enable = 1'b1; if_addr = 32'h100;
        if_q.push_back(32'h0000_0513);
        tick();
        check("fetch_a0", mem_a, 32'h100);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("fetch_a", mem_a, 32'h100 + 32'(k));
            check("fetch_early_done", if_done, 1'b0);
        end
        tick();
        check("fetch_e4_done", if_done, 1'b0);
        tick();
        check("fetch_done", if_done, 1'b1);
        check("fetch_data", if_data, if_q.pop_front());
        tick();
        check("fetch_single_pulse", if_done, 1'b0);
        if_enable = 1'b0;
        tick();
        check("fetch_no_reaccept", {if_done, mem_wr}, 2'b00);

        // Simultaneous requests: the load goes first
        if_enable = 1'b1; if_addr = 32'h104;
        ls_enable = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h200;
        ls_q.push_back(32'h0000_00F0);
        if_q.push_back(32'h0010_0093);
        wait_done(1'b0, 10, n);
        check("arb_load_lat", 64'(n), 64'd3);
        check("arb_load_data", ls_rdata, ls_q.pop_front());
        check("arb_if_waiting", if_done, 1'b0);
        ls_enable = 1'b0;
        tick();
        check("arb_fetch_start", mem_a, 32'h104);
        wait_done(1'b1, 10, n);
        check("arb_fetch_lat", 64'(n), 64'd5);
        check("arb_fetch_data", if_data, if_q.pop_front());
        if_enable = 1'b0;
        tick();

        // Word store
        ls_enable = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'hDEAD_BEEF;
        push_word_writes(32'h300, 32'hDEAD_BEEF, 4);
        wait_done(1'b0, 10, n);
        check("store_lat", 64'(n), 64'd5);
        check("store_wr_low", mem_wr, 1'b0);
        ls_enable = 1'b0;
        check_writes("store_bytes");
        tick();

        // IO store stalled by a full buffer; fetch proceeds meanwhile
        io_buffer_full = 1'b1;
        ls_enable = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_005A;
        if_enable = 1'b1; if_addr = 32'h100;
        if_q.push_back(32'h0000_0513);
        wexp.push_back({32'h0003_0000, 8'h5A});
        tick();
        check("io_fetch_first", {mem_a, mem_wr}, {32'h100, 1'b0});
        tick(); tick();
        check("io_stall_wr", mem_wr, 1'b0);
        io_buffer_full = 1'b0;
        wait_done(1'b1, 10, n);
        check("io_fetch_lat", 64'(n), 64'd3);
        check("io_fetch_data", if_data, if_q.pop_front());
        check("io_wr_during_done", mem_wr, 1'b0);
        if_enable = 1'b0;
        tick();
        check("io_store_start", {mem_a, mem_dout, mem_wr}, {32'h0003_0000, 8'h5A, 1'b1});
        tick();
        check("io_store_done", {ls_done, mem_wr}, 2'b10);
        ls_enable = 1'b0;
        check_writes("io_store");
        tick();

        // Flush mid-fetch, then a clean fetch
        if_enable = 1'b1; if_addr = 32'h100;
        tick(); tick();
        clear = 1'b1;
        tick();
        check("flush_no_done", {if_done, mem_wr}, 2'b00);
        clear = 1'b0; if_addr = 32'h104;
        if_q.push_back(32'h0010_0093);
        wait_done(1'b1, 10, n);
        check("flush_refetch_lat", 64'(n), 64'd6);
        check("flush_refetch_data", if_data, if_q.pop_front());
        if_enable = 1'b0;
        tick();

        // Flush has no effect on a load
        ls_enable = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h100;
        ls_q.push_back(32'h0000_0513);
        tick();
        clear = 1'b1;
        wait_done(1'b0, 10, n);
        check("clear_load_lat", 64'(n), 64'd3);
        check("clear_load_data", ls_rdata, ls_q.pop_front());
        clear = 1'b0; ls_enable = 1'b0;
        tick();

        // Reset while the third byte of a store is on the bus
        ls_enable = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h310; ls_wdata = 32'h1122_3344;
        push_word_writes(32'h310, 32'h1122_3344, 2);
        tick(); tick(); tick();
        check("rst_store_byte2", {mem_a, mem_dout, mem_wr}, {32'h312, 8'h22, 1'b1});
        rst = 1'b1; ls_enable = 1'b0;
        tick();
        check("rst_mid_ctl", {mem_a, mem_dout, mem_wr, if_done, ls_done}, 64'd0);
        check("rst_mid_data", {if_data, ls_rdata}, 64'd0);
        rst = 1'b0;
        tick();
        check("rst_idle", {ls_done, mem_wr}, 2'b00);
        check_writes("rst_store");

        // rdy low for three cycles mid-fetch
        if_enable = 1'b1; if_addr = 32'h104;
        if_q.push_back(32'h0010_0093);
        tick(); tick(); tick();
        check("rdy_pre_a", mem_a, 32'h106);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rdy_hold", {mem_a, if_done}, {32'h106, 1'b0});
        end
        rdy = 1'b1;
        wait_done(1'b1, 10, n);
        check("rdy_fetch_lat", 64'(n), 64'd3);
        check("rdy_fetch_data", if_data, if_q.pop_front());
        if_enable = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
